// File: rtl/tl_mem_adapter.sv
// ---------------------------------------------------------------------------
// tl_mem_adapter
//
// TL-UL slave front-end placed directly upstream of tl_memory. Each accepted
// A-channel request (Get / PutFullData / PutPartialData) produces exactly one
// single-cycle memory read or write pulse. The adapter then waits for the
// matching completion pulse and answers with a D-channel AccessAck or
// AccessAckData. Only one transaction is in flight at a time; A and D never
// overlap.
//
// Optional feature macro: TL_MEM_ADAPTER_TIMEOUT_EN
//   When defined, a watchdog started in ISSUE and advanced in WAIT forces a
//   denied response after TIMEOUT_CYCLES cycles with no completion pulse.
//   When undefined, WAIT waits forever for completion.
//
// Widths: `TL_ADDR_BITS and `TL_DATA_BYTES normally come from tl_pkg.vh; the
// fallback values below keep this file self-contained when that header has
// not been included ahead of it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_ready          A-channel handshake (a_ready high only in IDLE)
//   a_opcode/size/source     request attributes (0=PutFull,1=PutPartial,4=Get)
//   a_address/mask/data      request address, byte enables, put data
//   d_valid/d_ready          D-channel handshake
//   d_opcode/size/source     response attributes (0=AccessAck,1=AccessAckData)
//   d_data/d_denied          read data and error flag
//   mem_write_*              write pulse, address, data, mask; write_ready in
//   mem_read_*               read pulse, address; read data + valid in
// ---------------------------------------------------------------------------
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_mem_adapter #(
  parameter int SOURCE_BITS    = 4,
  parameter int SIZE_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  // A channel
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [2:0]                    a_opcode,
  input  logic [SIZE_BITS-1:0]          a_size,
  input  logic [SOURCE_BITS-1:0]        a_source,
  input  logic [`TL_ADDR_BITS-1:0]      a_address,
  input  logic [`TL_DATA_BYTES-1:0]     a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]   a_data,
  // D channel
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [2:0]                    d_opcode,
  output logic [SIZE_BITS-1:0]          d_size,
  output logic [SOURCE_BITS-1:0]        d_source,
  output logic [`TL_DATA_BYTES*8-1:0]   d_data,
  output logic                          d_denied,
  // memory write port
  output logic                          mem_write_valid,
  output logic [`TL_ADDR_BITS-1:0]      mem_write_addr,
  output logic [`TL_DATA_BYTES*8-1:0]   mem_write_data,
  output logic [`TL_DATA_BYTES-1:0]     mem_write_mask,
  input  logic                          mem_write_ready,
  // memory read port
  output logic                          mem_read_valid,
  output logic [`TL_ADDR_BITS-1:0]      mem_read_addr,
  input  logic [`TL_DATA_BYTES*8-1:0]   mem_read_data,
  input  logic                          mem_read_data_valid
);

  localparam int AW = `TL_ADDR_BITS;
  localparam int DW = `TL_DATA_BYTES * 8;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   addr_r;
  logic            is_get_r;

`ifdef TL_MEM_ADAPTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   cnt_r;
`endif

  // Opcodes this adapter turns into a memory operation.
  function automatic logic opcode_supported(input logic [2:0] op);
    case (op)
      OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET: opcode_supported = 1'b1;
      default:                             opcode_supported = 1'b0;
    endcase
  endfunction

  // Both memory ports see the address captured at the A fire.
  assign mem_write_addr = addr_r;
  assign mem_read_addr  = addr_r;

  // Request FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      addr_r          <= {AW{1'b0}};
      is_get_r        <= 1'b0;
      a_ready         <= 1'b1;
      d_valid         <= 1'b0;
      d_opcode        <= 3'd0;
      d_size          <= {SIZE_BITS{1'b0}};
      d_source        <= {SOURCE_BITS{1'b0}};
      d_data          <= {DW{1'b0}};
      d_denied        <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_write_data  <= {DW{1'b0}};
      mem_write_mask  <= {`TL_DATA_BYTES{1'b0}};
      mem_read_valid  <= 1'b0;
`ifdef TL_MEM_ADAPTER_TIMEOUT_EN
      cnt_r           <= {CW{1'b0}};
`endif
    end else begin
      // Memory strobes default low so they can never last beyond ISSUE;
      // tl_memory would treat a second high cycle as a new operation.
      mem_write_valid <= 1'b0;
      mem_read_valid  <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (a_valid && a_ready) begin
            a_ready        <= 1'b0;
            addr_r         <= a_address;
            is_get_r       <= (a_opcode == OP_GET);
            d_size         <= a_size;
            d_source       <= a_source;
            d_data         <= {DW{1'b0}};
            d_denied       <= 1'b0;
            mem_write_data <= a_data;
            mem_write_mask <= a_mask;
            if (opcode_supported(a_opcode)) begin
              // Raise the strobe now so it is high for exactly the ISSUE cycle.
              state_r <= ST_ISSUE;
              if (a_opcode == OP_GET) begin
                mem_read_valid <= 1'b1;
              end else begin
                mem_write_valid <= 1'b1;
              end
            end else begin
              // Unsupported opcode: answer immediately, no memory access.
              state_r  <= ST_RESP;
              d_valid  <= 1'b1;
              d_opcode <= D_ACK;
              d_denied <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          state_r <= ST_WAIT;
`ifdef TL_MEM_ADAPTER_TIMEOUT_EN
          // The ISSUE cycle is the first counted cycle.
          cnt_r   <= {{(CW-1){1'b0}}, 1'b1};
`endif
        end

        ST_WAIT: begin
          // Only the completion kind matching the request is honoured.
          if (is_get_r && mem_read_data_valid) begin
            state_r  <= ST_RESP;
            d_valid  <= 1'b1;
            d_opcode <= D_ACK_DATA;
            d_data   <= mem_read_data;
          end else if (!is_get_r && mem_write_ready) begin
            state_r  <= ST_RESP;
            d_valid  <= 1'b1;
            d_opcode <= D_ACK;
`ifdef TL_MEM_ADAPTER_TIMEOUT_EN
          end else if (cnt_r >= CW'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expiry: denied response, opcode still follows the request.
            state_r  <= ST_RESP;
            d_valid  <= 1'b1;
            d_opcode <= is_get_r ? D_ACK_DATA : D_ACK;
            d_data   <= {DW{1'b0}};
            d_denied <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
`else
          end else begin
            state_r <= ST_WAIT;
`endif
          end
        end

        ST_RESP: begin
          // d_* stay frozen until the response is taken.
          if (d_ready) begin
            state_r <= ST_IDLE;
            d_valid <= 1'b0;
            a_ready <= 1'b1;
          end else begin
            state_r <= ST_RESP;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          d_valid <= 1'b0;
          a_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_mem_adapter.sv
// ---------------------------------------------------------------------------
// tb_tl_mem_adapter
//
// Drives tl_mem_adapter against a behavioural tl_memory stand-in (words
// initialised to {8'hAA, word index}, completion pulse a fixed latency after
// each request pulse). A table of requests with expected responses is applied
// in a loop; expected D responses go onto a scoreboard queue when the request
// is driven and are compared when the D handshake happens. Hand-written
// sequences cover back-pressure, wrong-kind completions, reset in WAIT and
// (with TL_MEM_ADAPTER_TIMEOUT_EN) the watchdog.
// ---------------------------------------------------------------------------
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tb_tl_mem_adapter;
  localparam int AW = `TL_ADDR_BITS;
  localparam int DB = `TL_DATA_BYTES;
  localparam int DW = DB * 8;
  localparam int MEM_LAT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_ready;
  logic [2:0]    a_opcode = 3'd0;
  logic [2:0]    a_size = 3'd0;
  logic [3:0]    a_source = 4'd0;
  logic [AW-1:0] a_address = '0;
  logic [DB-1:0] a_mask = '0;
  logic [DW-1:0] a_data = '0;
  logic          d_valid, d_ready = 1'b0;
  logic [2:0]    d_opcode, d_size;
  logic [3:0]    d_source;
  logic [DW-1:0] d_data;
  logic          d_denied;
  logic          mem_write_valid, mem_write_ready;
  logic [AW-1:0] mem_write_addr, mem_read_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic [DB-1:0] mem_write_mask;
  logic          mem_read_valid, mem_read_data_valid;

  tl_mem_adapter #(.SOURCE_BITS(4), .SIZE_BITS(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .mem_write_ready(mem_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid)
  );

  // ---------------- memory stand-in ----------------
  logic [DW-1:0] mem [16];
  logic          mem_hold = 1'b0;          // suppress completion pulses
  logic          inj_rd = 1'b0, inj_wr = 1'b0;
  logic          mr_done, mw_done, pend_rd;
  int            pend_cnt;
  int            rd_pulses = 0, wr_pulses = 0;
  logic [AW-1:0] last_rd_addr, last_wr_addr;

  assign mem_read_data_valid = mr_done | inj_rd;
  assign mem_write_ready     = mw_done | inj_wr;

  always @(posedge clk) begin
    mr_done <= 1'b0;
    mw_done <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= {8'hAA, 56'(i)};
      pend_cnt      <= 0;
      pend_rd       <= 1'b0;
      mem_read_data <= '0;
    end else begin
      if (mem_read_valid) begin
        rd_pulses     <= rd_pulses + 1;
        last_rd_addr  <= mem_read_addr;
        mem_read_data <= mem[mem_read_addr[6:3]];
        pend_cnt      <= MEM_LAT;
        pend_rd       <= 1'b1;
      end else if (mem_write_valid) begin
        wr_pulses    <= wr_pulses + 1;
        last_wr_addr <= mem_write_addr;
        for (int b = 0; b < DB; b++)
          if (mem_write_mask[b]) mem[mem_write_addr[6:3]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
        pend_cnt <= MEM_LAT;
        pend_rd  <= 1'b0;
      end else if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1 && !mem_hold) begin
          if (pend_rd) mr_done <= 1'b1;
          else         mw_done <= 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    size;
    logic [3:0]    src;
    logic [DW-1:0] data;
    logic          den;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && d_valid && d_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: response op=%0d data=0x%016h with no expected entry", d_opcode, d_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (d_opcode !== mon_e.op || d_size !== mon_e.size || d_source !== mon_e.src ||
            d_data !== mon_e.data || d_denied !== mon_e.den) begin
          n_fail++;
          $display("FAIL sb_resp: got op=%0d size=%0d src=%0d data=0x%016h den=%0b, expected op=%0d size=%0d src=%0d data=0x%016h den=%0b",
                   d_opcode, d_size, d_source, d_data, d_denied,
                   mon_e.op, mon_e.size, mon_e.src, mon_e.data, mon_e.den);
        end
      end
    end
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [3:0]    src;
    logic [DW-1:0] data;
    logic [DB-1:0] mask;
    logic [2:0]    e_op;
    logic          e_den;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[10];

  // Wait for a_ready, present one request, return after its fire edge.
  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    int   t = 0;
    while (!a_ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("a_ready_before_req", {63'd0, a_ready}, 64'd1);
    a_valid = 1'b1; a_opcode = v.op; a_address = v.addr; a_size = v.size;
    a_source = v.src; a_data = v.data; a_mask = v.mask;
    if (push) begin
      e.op = v.e_op; e.size = v.size; e.src = v.src; e.data = v.e_data; e.den = v.e_den;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("a_ready_low_after_fire", {63'd0, a_ready}, 64'd0);
  endtask

  // Edges from the fire edge until d_valid is seen; bounded.
  task automatic wait_dvalid(output int lat);
    lat = 0;
    while (!d_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    chk("d_valid_low_after_hs", {63'd0, d_valid}, 64'd0);
    chk("a_ready_after_hs", {63'd0, a_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  rd0, wr0, lat;
    bit  is_get, is_put;
    is_get = (v.op == 3'd4);
    is_put = (v.op == 3'd0) || (v.op == 3'd1);
    rd0 = rd_pulses; wr0 = wr_pulses;
    issue(v, 1'b1);
    wait_dvalid(lat);
    chk($sformatf("latency_v%0d", idx), 64'(lat), (is_get || is_put) ? 64'd9 : 64'd0);
    handshake();
    chk($sformatf("rd_pulses_v%0d", idx), 64'(rd_pulses - rd0), is_get ? 64'd1 : 64'd0);
    chk($sformatf("wr_pulses_v%0d", idx), 64'(wr_pulses - wr0), is_put ? 64'd1 : 64'd0);
    if (is_get) chk($sformatf("rd_addr_v%0d", idx), 64'(last_rd_addr), 64'(v.addr));
    else if (is_put) chk($sformatf("wr_addr_v%0d", idx), 64'(last_wr_addr), 64'(v.addr));
    else chk($sformatf("no_access_v%0d", idx), 64'(rd_pulses - rd0 + wr_pulses - wr0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t v;
    int   lat;
    //          op    addr       size  src    data                    mask   e_op  den   e_data
    vecs[0] = '{3'd4, 32'h18, 3'd3, 4'd3,  64'h0,                 8'h00, 3'd1, 1'b0, 64'hAA00000000000003};
    vecs[1] = '{3'd0, 32'h08, 3'd3, 4'd1,  64'h1122334455667788,  8'hFF, 3'd0, 1'b0, 64'h0};
    vecs[2] = '{3'd4, 32'h08, 3'd3, 4'd2,  64'h0,                 8'h00, 3'd1, 1'b0, 64'h1122334455667788};
    vecs[3] = '{3'd1, 32'h10, 3'd2, 4'd4,  64'h00000000DEADBEEF,  8'h0F, 3'd0, 1'b0, 64'h0};
    vecs[4] = '{3'd4, 32'h10, 3'd3, 4'd5,  64'h0,                 8'h00, 3'd1, 1'b0, 64'hAA000000DEADBEEF};
    vecs[5] = '{3'd2, 32'h20, 3'd3, 4'd6,  64'h0,                 8'h00, 3'd0, 1'b1, 64'h0};
    vecs[6] = '{3'd7, 32'h28, 3'd1, 4'd7,  64'h0,                 8'h00, 3'd0, 1'b1, 64'h0};
    vecs[7] = '{3'd4, 32'h38, 3'd2, 4'd15, 64'h0,                 8'h00, 3'd1, 1'b0, 64'hAA00000000000007};
    vecs[8] = '{3'd1, 32'h38, 3'd3, 4'd8,  64'h1234567800000000,  8'hF0, 3'd0, 1'b0, 64'h0};
    vecs[9] = '{3'd4, 32'h38, 3'd3, 4'd9,  64'h0,                 8'h00, 3'd1, 1'b0, 64'h1234567800000007};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_a_ready", {63'd0, a_ready}, 64'd1);
    chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_mem_valids", {62'd0, mem_read_valid, mem_write_valid}, 64'd0);
    chk("rst_d_denied", {63'd0, d_denied}, 64'd0);
    chk("rst_d_data", d_data, 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-pressure: response frozen while d_ready stays low.
    issue(vecs[0], 1'b1);
    wait_dvalid(lat);
    chk("bp_latency", 64'(lat), 64'd9);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_c%0d", c),
          {d_data[31:0], 17'd0, d_valid, a_ready, d_denied, d_opcode, d_size, d_source},
          {32'h00000003, 17'd0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd3, 4'd3});
    end
    handshake();

    // Completion of the wrong kind is ignored in WAIT.
    mem_hold = 1'b1;
    v = '{3'd0, 32'h20, 3'd3, 4'd10, 64'h0102030405060708, 8'hFF, 3'd0, 1'b0, 64'h0};
    issue(v, 1'b1);
    @(posedge clk); #1;
    inj_rd = 1'b1;
    @(posedge clk); #1;
    inj_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("wrong_kind_ignored", {63'd0, d_valid}, 64'd0);
    inj_wr = 1'b1;
    @(posedge clk); #1;
    inj_wr = 1'b0;
    chk("right_kind_resp", {63'd0, d_valid}, 64'd1);
    handshake();
    repeat (3) @(posedge clk);
    #1 mem_hold = 1'b0;

    // Reset while waiting for memory: back to IDLE, no response ever.
    mem_hold = 1'b1;
    issue(vecs[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wait_a_ready", {63'd0, a_ready}, 64'd1);
    chk("rst_wait_d_valid", {63'd0, d_valid}, 64'd0);
    repeat (12) @(posedge clk);
    #1 chk("rst_wait_no_resp", {63'd0, d_valid}, 64'd0);
    mem_hold = 1'b0;

`ifdef TL_MEM_ADAPTER_TIMEOUT_EN
    // Watchdog: Get with completion withheld, denied response 8 cycles after ISSUE.
    mem_hold = 1'b1;
    v = '{3'd4, 32'h18, 3'd3, 4'd11, 64'h0, 8'h00, 3'd1, 1'b1, 64'h0};
    issue(v, 1'b1);
    wait_dvalid(lat);
    chk("timeout_latency", 64'(lat), 64'd8);
    handshake();
    repeat (10) @(posedge clk);
    #1 mem_hold = 1'b0;
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
